// File: rtl/fact_slave_core.sv
// Bus-mapped factorial accelerator: computes N! mod 2^128 with a radix-2
// shift-add multiplier and raises a level interrupt when the job completes.
module fact_slave_core #(
    parameter int MUL_STEPS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_sel,
    input  logic        s_wr,
    input  logic [7:0]  s_addr,
    input  logic [63:0] s_din,
    output logic [63:0] s_dout,
    output logic        interrupt
);

    localparam int STEP_W = $clog2(MUL_STEPS + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MUL_STEPS - 1);

    localparam logic [4:0] OFF_START   = 5'd0;
    localparam logic [4:0] OFF_CLEAR   = 5'd1;
    localparam logic [4:0] OFF_DONE    = 5'd2;
    localparam logic [4:0] OFF_INTR_EN = 5'd3;
    localparam logic [4:0] OFF_OPERAND = 5'd4;
    localparam logic [4:0] OFF_RES_H   = 5'd5;
    localparam logic [4:0] OFF_RES_L   = 5'd6;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DEC,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [63:0]       operand;
    logic [127:0]      result;
    logic [127:0]      acc;
    logic [127:0]      mcand;
    logic [63:0]       mplier;
    logic [63:0]       cnt;
    logic [STEP_W-1:0] step;
    logic              intr_en;

    logic [4:0] offset;
    logic       wr_en;
    logic       start_req;
    logic       clear_req;
    logic       busy;
    logic       done;
    logic       addr_lsb_unused;

    assign offset          = s_addr[7:3];
    assign addr_lsb_unused = ^s_addr[2:0];
    assign wr_en           = s_sel & s_wr;
    assign start_req       = wr_en && (offset == OFF_START) && s_din[0];
    assign clear_req       = wr_en && (offset == OFF_CLEAR) && s_din[0];

    assign busy      = (state == MUL) || (state == DEC);
    assign done      = (state == DONE);
    assign interrupt = intr_en & done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // N<=1 skips multiplication: DEC with cnt<=2 copies acc (preset to 1) and finishes.
    always_comb begin
        state_next = state;
        if (clear_req) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_req) begin
                        state_next = (operand <= 64'd1) ? DEC : MUL;
                    end
                end
                MUL: begin
                    if (step == LAST_STEP) begin
                        state_next = DEC;
                    end
                end
                DEC: begin
                    state_next = (cnt <= 64'd2) ? DONE : MUL;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            operand <= '0;
            result  <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            step    <= '0;
            intr_en <= 1'b0;
        end else begin
            if (wr_en && (offset == OFF_INTR_EN)) begin
                intr_en <= s_din[0];
            end
            if (clear_req) begin
                operand <= '0;
                result  <= '0;
                acc     <= '0;
                mcand   <= '0;
                mplier  <= '0;
                cnt     <= '0;
                step    <= '0;
            end else begin
                if (wr_en && (offset == OFF_OPERAND) && !busy) begin
                    operand <= s_din;
                end
                case (state)
                    IDLE, DONE: begin
                        if (start_req) begin
                            result <= 128'd1;
                            cnt    <= operand;
                            mcand  <= 128'd1;
                            mplier <= operand;
                            acc    <= (operand <= 64'd1) ? 128'd1 : 128'd0;
                            step   <= '0;
                        end
                    end
                    // One multiplier bit per cycle; the 128-bit shift truncates naturally.
                    MUL: begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        step   <= step + STEP_W'(1);
                    end
                    DEC: begin
                        result <= acc;
                        cnt    <= cnt - 64'd1;
                        mcand  <= acc;
                        mplier <= cnt - 64'd1;
                        acc    <= '0;
                        step   <= '0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_comb begin
        s_dout = '0;
        if (s_sel && !s_wr) begin
            case (offset)
                OFF_DONE:    s_dout = {62'b0, busy, done};
                OFF_INTR_EN: s_dout = {63'b0, intr_en};
                OFF_OPERAND: s_dout = operand;
                OFF_RES_H:   s_dout = result[127:64];
                OFF_RES_L:   s_dout = result[63:0];
                default:     s_dout = '0;
            endcase
        end
    end

endmodule
